// File: rtl/mv_diff_if.sv
// Sample-stream bundle for the mv_diff sliding-window comb.
//   data_in        : signed input sample, valid when data_in_valid=1
//   data_in_valid  : input strobe, gaps of any length allowed
//   data_out       : signed x[n]-x[n-N], one bit wider than the input
//   data_out_valid : one-cycle strobe per accepted input sample
//   primed         : window holds N samples, so data_out is a true difference
// master = sample source / consumer side, slave = the comb itself.
interface mv_diff_if #(
  parameter int DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         data_in_valid;
  logic signed [DATA_WIDTH:0]   data_out;
  logic                         data_out_valid;
  logic                         primed;

  modport master (
    output data_in, data_in_valid,
    input  data_out, data_out_valid, primed
  );

  modport slave (
    input  data_in, data_in_valid,
    output data_out, data_out_valid, primed
  );
endinterface

// File: rtl/mv_diff.sv
// Sliding-window comb (differentiator): y[n] = x[n] - x[n-N], N = 2^LOG2_LEN.
// Companion of the moving-average integrator; feeds energy-step / plateau-edge
// detection ahead of the correlator threshold.
// Ports:
//   clk   : clock, all registers on posedge
//   rst   : synchronous reset, active-high; also forces data_out to 0
//   clear : synchronous window flush; data_out keeps its value
//   bus   : mv_diff_if.slave sample stream (data_in/valid in, data_out/valid/primed out)
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | fewer than N samples written; output is the new sample minus zero
// RUN   | window full; output is new sample minus the sample leaving it
module mv_diff #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_LEN   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  mv_diff_if.slave   bus
);
  localparam int N = 1 << LOG2_LEN;

  typedef enum logic {FILL, RUN} state_t;

  state_t                       state_q, state_d;
  logic [LOG2_LEN-1:0]          wr_ptr_q, wr_ptr_d;
  logic [LOG2_LEN-1:0]          fill_cnt_q, fill_cnt_d;
  logic signed [DATA_WIDTH:0]   data_out_q, data_out_d;
  logic                         data_out_valid_q, data_out_valid_d;
  logic                         primed_q, primed_d;

  // Window RAM is never reset: RUN is only reached after N fresh writes,
  // so stale contents are never read into a difference.
  logic signed [DATA_WIDTH-1:0] mem_q [N];

  logic signed [DATA_WIDTH-1:0] old_sample;
  logic signed [DATA_WIDTH:0]   ext_in, ext_old;
  logic                         accept;

  // Read-before-write: the slot being overwritten is the sample leaving the window.
  assign old_sample = mem_q[wr_ptr_q];
  assign ext_in     = {bus.data_in[DATA_WIDTH-1], bus.data_in};
  assign ext_old    = {old_sample[DATA_WIDTH-1], old_sample};
  // clear drops a coincident sample.
  assign accept     = bus.data_in_valid & ~clear;

  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    fill_cnt_d       = fill_cnt_q;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    primed_d         = primed_q;
    if (clear) begin
      state_d    = FILL;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      primed_d   = 1'b0;
    end else if (bus.data_in_valid) begin
      wr_ptr_d         = wr_ptr_q + LOG2_LEN'(1);
      data_out_valid_d = 1'b1;
      if (state_q == FILL) begin
        data_out_d = ext_in;
        fill_cnt_d = fill_cnt_q + LOG2_LEN'(1);
        if (fill_cnt_q == LOG2_LEN'(N - 1)) begin
          state_d = RUN;
        end
      end else begin
        data_out_d = ext_in - ext_old;
        primed_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= FILL;
      wr_ptr_q         <= '0;
      fill_cnt_q       <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      primed_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      fill_cnt_q       <= fill_cnt_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      primed_q         <= primed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.primed         = primed_q;
endmodule

// File: tb/tb_mv_diff.sv
// Self-checking bench for mv_diff: a short-window instance (N=4) for the
// directed cases and a long-window instance (N=32) for a random gapped stream.
// Each accepted sample pushes its expected output (value, primed, cycle) to a
// scoreboard queue; the output monitor pops and compares on every strobe.
module tb_mv_diff;
  localparam int DW = 16;
  localparam int NS = 4;
  localparam int NL = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s, rst_l, clr_s, clr_l;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mv_diff_if #(.DATA_WIDTH(DW)) ifs ();
  mv_diff_if #(.DATA_WIDTH(DW)) ifl ();

  mv_diff #(.DATA_WIDTH(DW), .LOG2_LEN(2)) dut_s (
    .clk(clk), .rst(rst_s), .clear(clr_s), .bus(ifs)
  );
  mv_diff #(.DATA_WIDTH(DW), .LOG2_LEN(5)) dut_l (
    .clk(clk), .rst(rst_l), .clear(clr_l), .bus(ifl)
  );

  typedef struct {
    int d;
    int p;
    int c;
  } exp_t;

  exp_t                 qs[$], ql[$];
  logic signed [DW-1:0] hist_s[$], hist_l[$];
  int                   n_tests = 0;
  int                   n_fail  = 0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Golden comb: newest sample minus the sample N accepted inputs ago (0 if none).
  function automatic exp_t model(input logic signed [DW-1:0] x,
                                 input int hsize, input int oldest, input int n);
    exp_t e;
    e.d = int'(x) - ((hsize >= n) ? oldest : 0);
    e.p = (hsize >= n) ? 1 : 0;
    e.c = cyc + 1;
    return e;
  endfunction

  task automatic drive_s(input bit v, input logic signed [DW-1:0] x,
                         input bit clr, input bit r);
    int old;
    @(posedge clk); #1;
    ifs.data_in_valid = v;
    ifs.data_in       = x;
    clr_s             = clr;
    rst_s             = r;
    if (r || clr) begin
      hist_s.delete();
    end else if (v) begin
      old = (hist_s.size() >= NS) ? int'(hist_s[hist_s.size()-NS]) : 0;
      qs.push_back(model(x, hist_s.size(), old, NS));
      hist_s.push_back(x);
    end
  endtask

  task automatic drive_l(input bit v, input logic signed [DW-1:0] x);
    int old;
    @(posedge clk); #1;
    ifl.data_in_valid = v;
    ifl.data_in       = x;
    if (v) begin
      old = (hist_l.size() >= NL) ? int'(hist_l[hist_l.size()-NL]) : 0;
      ql.push_back(model(x, hist_l.size(), old, NL));
      hist_l.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifs.data_out_valid === 1'b1) begin
      chk("s_strobe_expected", qs.size() > 0, 1);
      if (qs.size() > 0) begin
        e = qs.pop_front();
        chk("s_data", ifs.data_out, e.d);
        chk("s_primed", ifs.primed, e.p);
        chk("s_latency", cyc, e.c);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ifl.data_out_valid === 1'b1) begin
      chk("l_strobe_expected", ql.size() > 0, 1);
      if (ql.size() > 0) begin
        e = ql.pop_front();
        chk("l_data", ifl.data_out, e.d);
        chk("l_primed", ifl.primed, e.p);
        chk("l_latency", cyc, e.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    rst_s = 1'b1; rst_l = 1'b1; clr_s = 1'b0; clr_l = 1'b0;
    ifs.data_in_valid = 1'b0; ifs.data_in = '0;
    ifl.data_in_valid = 1'b0; ifl.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_s = 1'b0; rst_l = 1'b0;
    @(negedge clk);
    chk("rst_data", ifs.data_out, 0);
    chk("rst_valid", ifs.data_out_valid, 0);
    chk("rst_primed", ifs.primed, 0);
    chk("rst_l_primed", ifl.primed, 0);

    // Ramp, valid every clock.
    for (int i = 1; i <= 10; i++) drive_s(1'b1, DW'(i), 1'b0, 1'b0);
    repeat (3) drive_s(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_hold_data", ifs.data_out, 4);
    chk("idle_hold_primed", ifs.primed, 1);

    // Same ramp, valid on every third clock.
    drive_s(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      drive_s(1'b1, DW'(i), 1'b0, 1'b0);
      drive_s(1'b0, '0, 1'b0, 1'b0);
      drive_s(1'b0, '0, 1'b0, 1'b0);
    end

    // Full-scale steps in both directions.
    drive_s(1'b0, '0, 1'b1, 1'b0);
    repeat (4) drive_s(1'b1, -16'sd32768, 1'b0, 1'b0);
    drive_s(1'b1, 16'sd32767, 1'b0, 1'b0);
    drive_s(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pos_full_scale", ifs.data_out, 65535);
    drive_s(1'b0, '0, 1'b1, 1'b0);
    repeat (4) drive_s(1'b1, 16'sd32767, 1'b0, 1'b0);
    drive_s(1'b1, -16'sd32768, 1'b0, 1'b0);
    drive_s(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("neg_full_scale", ifs.data_out, -65535);

    // clear together with a sample: sample dropped, data_out held.
    drive_s(1'b0, '0, 1'b1, 1'b0);
    repeat (4) drive_s(1'b1, 16'sd5, 1'b0, 1'b0);
    drive_s(1'b1, 16'sd5, 1'b1, 1'b0);
    drive_s(1'b1, 16'sd9, 1'b0, 1'b0);
    @(negedge clk);
    chk("clr_hold_data", ifs.data_out, 5);
    chk("clr_valid", ifs.data_out_valid, 0);
    chk("clr_primed", ifs.primed, 0);
    for (int i = 1; i <= 4; i++) drive_s(1'b1, DW'(i), 1'b0, 1'b0);

    // rst pulse while in RUN, then restart.
    drive_s(1'b0, '0, 1'b0, 1'b1);
    drive_s(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_run_data", ifs.data_out, 0);
    chk("rst_run_valid", ifs.data_out_valid, 0);
    chk("rst_run_primed", ifs.primed, 0);
    repeat (5) drive_s(1'b1, 16'sd7, 1'b0, 1'b0);
    repeat (3) drive_s(1'b0, '0, 1'b0, 1'b0);

    // Long window, random stream with random gaps.
    for (int k = 0; k < 1000; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) drive_l(1'b0, '0);
      drive_l(1'b1, DW'($urandom));
    end
    repeat (4) drive_l(1'b0, '0);
    @(negedge clk);
    chk("s_drained", qs.size(), 0);
    chk("l_drained", ql.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
